fifo_pull_serializer: RTL
=========================

# fifo_pull_serializer

Read-side consumer for the team's FIFO buffer. Pops one word at a time through the FIFO's pull/head/counter interface and transmits each word as a framed serial bit stream: start bit, data MSB-first, even parity, stop bit. Each bit is held for a programmable number of clock cycles. Sits between the FIFO head and an off-block serial line or link.

## Interface
- BUFFER_WIDTH, 23, data word width in bits; must match the FIFO.
- COUNT_WIDTH, 5, width of the FIFO occupancy counter.
- BIT_PERIOD, 4, clock cycles per serial bit, ≥1.
- clock  input  1  single clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- enable  input  1  permits a new frame to start; sampled only in IDLE.
- fifo_head  input  BUFFER_WIDTH  FIFO first-word-fall-through output; valid whenever fifo_count ≠ 0.
- fifo_count  input  COUNT_WIDTH  FIFO occupancy.
- pull  output  1  registered; one-cycle pop strobe to the FIFO.
- ser_out  output  1  serial line; idles high.
- busy  output  1  high from LOAD through the last STOP cycle.
- words_sent  output  16  count of completed frames; wraps 0xFFFF→0.

## Operation
- Reset values: state IDLE, pull=0, ser_out=1, busy=0, words_sent=0, shift register=0, bit and period counters=0.
- IDLE:
  - ser_out=1.
  - If enable=1 and fifo_count≠0 at a clock edge: pull←1, busy←1, go to LOAD.
- LOAD (exactly 1 cycle, pull=1):
  - fifo_head is valid during this cycle, and the FIFO pops at the closing edge.
  - At that edge: shift←fifo_head, parity←XOR of fifo_head, pull←0, ser_out←0, go to START.
- START: ser_out=0 for BIT_PERIOD cycles, then go to DATA.
- DATA:
  - Sends BUFFER_WIDTH bits, MSB first; each bit is held BIT_PERIOD cycles.
  - Shift left on each bit boundary.
  - After the last bit, go to PARITY.
- PARITY: ser_out = even-parity bit (XOR of all data bits) for BIT_PERIOD cycles, then go to STOP.
- STOP:
  - ser_out=1 for BIT_PERIOD cycles.
  - At the final edge: words_sent←words_sent+1, busy←0, go to IDLE.
- enable deasserted mid-frame: no effect; the frame completes.
- fifo_count changing mid-frame: ignored; occupancy is checked only in IDLE.
- pull is never asserted outside LOAD, so the block never pops an empty FIFO.
- Reset mid-frame:
  - The block returns to IDLE at once and ser_out goes high.
  - A word already popped is lost; words_sent is cleared.
- words_sent wraps modulo 2^16 with no flag.

## Timing
- Frame length: (BUFFER_WIDTH+3)×BIT_PERIOD cycles, measured from the first START cycle to the last STOP cycle.
- Start latency: IDLE edge with the condition true → LOAD cycle → start bit begins on the next cycle. That is 2 cycles from the qualifying edge to ser_out=0.
- Back-to-back frames:
  - Minimum 1 IDLE cycle + 1 LOAD cycle (ser_out=1) follow each stop bit.
  - Frame-to-frame period is therefore (BUFFER_WIDTH+3)×BIT_PERIOD+2 cycles.
- pull width is exactly 1 cycle per frame, with no pull pulses between frames.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset, then idle with fifo_count=0 and enable=1 for 50 cycles → ser_out=1, pull=0, busy=0, words_sent=0 throughout.
- BIT_PERIOD=4, fifo_head=0x2AAAAA, fifo_count=1, enable=1 → single 1-cycle pull, then 4 cycles of 0.
  - Data bits 0,1,0,1,… (MSB first, 23 bits), 4 cycles each.
  - Parity bit 1 (11 ones), then stop bit 1.
  - Frame is 104 cycles; words_sent=1 afterwards.
- Same setup with fifo_head=0x000003 → parity bit 0; last two data bits are 1,1.
- fifo_count=3 model FIFO with words 0x000001, 0x400000, 0x7FFFFF, enable held high → three frames with exactly 2 high cycles between stop and start.
  - Three pull pulses total; words_sent=3; parity bits 1,1,1.
- enable dropped during DATA of the first frame → that frame completes, no second pull occurs, busy falls after STOP.
- Reset asserted asynchronously mid-DATA → ser_out=1, pull=0, busy=0, words_sent=0 immediately.
  - After release with fifo_count≠0, a fresh frame starts 2 cycles after the first qualifying edge.

Source files
------------

// File: rtl/fifo_pull_serializer_if.sv
// rtl/fifo_pull_serializer_if.sv - FIFO pull side and serial line signals of the serializer
interface fifo_pull_serializer_if #(
  parameter int BUFFER_WIDTH = 23,
  parameter int COUNT_WIDTH  = 5
);
  logic                    enable;
  logic [BUFFER_WIDTH-1:0] fifo_head;
  logic [COUNT_WIDTH-1:0]  fifo_count;
  logic                    pull;
  logic                    ser_out;
  logic                    busy;
  logic [15:0]             words_sent;

  // Environment side: supplies the FIFO head/occupancy and observes the line.
  modport master (
    output enable, fifo_head, fifo_count,
    input  pull, ser_out, busy, words_sent
  );

  // Serializer side.
  modport slave (
    input  enable, fifo_head, fifo_count,
    output pull, ser_out, busy, words_sent
  );
endinterface

// File: rtl/fifo_pull_serializer.sv
// rtl/fifo_pull_serializer.sv - pops FIFO words and sends them as start/data/parity/stop frames
module fifo_pull_serializer #(
  parameter int BUFFER_WIDTH = 23,
  parameter int COUNT_WIDTH  = 5,
  parameter int BIT_PERIOD   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  fifo_pull_serializer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  localparam int PW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int BW = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(BIT_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BUFFER_WIDTH - 1);

  state_t                  state_q, state_d;
  logic                    pull_q, pull_d;
  logic                    ser_q, ser_d;
  logic                    busy_q, busy_d;
  logic [15:0]             words_q, words_d;
  logic [BUFFER_WIDTH-1:0] shift_q, shift_d;
  logic                    parity_q, parity_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]           per_cnt_q, per_cnt_d;
  logic                    period_end;

  assign period_end     = (per_cnt_q == PER_LAST);
  assign bus.pull       = pull_q;
  assign bus.ser_out    = ser_q;
  assign bus.busy       = busy_q;
  assign bus.words_sent = words_q;

  // Frame sequencing: every output is computed one cycle ahead and registered.
  always_comb begin
    state_d   = state_q;
    pull_d    = pull_q;
    ser_d     = ser_q;
    busy_d    = busy_q;
    words_d   = words_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    per_cnt_d = per_cnt_q;
    case (state_q)
      S_IDLE: begin
        ser_d = 1'b1;
        if (bus.enable && (bus.fifo_count != '0)) begin
          pull_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Head is valid now; the FIFO pops at this same edge.
        shift_d   = bus.fifo_head;
        parity_d  = ^bus.fifo_head;
        pull_d    = 1'b0;
        ser_d     = 1'b0;
        per_cnt_d = '0;
        state_d   = S_START;
      end
      S_START: begin
        if (period_end) begin
          per_cnt_d = '0;
          bit_cnt_d = '0;
          ser_d     = shift_q[BUFFER_WIDTH-1];
          state_d   = S_DATA;
        end else begin
          per_cnt_d = per_cnt_q + PW'(1);
        end
      end
      S_DATA: begin
        if (period_end) begin
          per_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            ser_d   = parity_q;
            state_d = S_PARITY;
          end else begin
            // Next bit is the one that moves into the MSB after the shift.
            shift_d   = shift_q << 1;
            ser_d     = shift_q[BUFFER_WIDTH-2];
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          per_cnt_d = per_cnt_q + PW'(1);
        end
      end
      S_PARITY: begin
        if (period_end) begin
          per_cnt_d = '0;
          ser_d     = 1'b1;
          state_d   = S_STOP;
        end else begin
          per_cnt_d = per_cnt_q + PW'(1);
        end
      end
      S_STOP: begin
        if (period_end) begin
          per_cnt_d = '0;
          words_d   = words_q + 16'd1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          per_cnt_d = per_cnt_q + PW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        pull_d  = 1'b0;
        ser_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; reset abandons any frame in flight and idles the line high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pull_q    <= 1'b0;
      ser_q     <= 1'b1;
      busy_q    <= 1'b0;
      words_q   <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      per_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pull_q    <= pull_d;
      ser_q     <= ser_d;
      busy_q    <= busy_d;
      words_q   <= words_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      per_cnt_q <= per_cnt_d;
    end
  end

endmodule
